spi_byte_master: RTL
====================

Name: spi_byte_master

Overview:
- Synthesizable SPI initiator that drives the existing SPI slave interface: ss, sclk and mosi as outputs, miso as input.
- Replaces bench-level bit-banging with an RTL byte engine in the sys_clk domain, for on-chip or FPGA control of the GPIO/mode command set.
- One byte per ss frame, MSB first, sclk idle low (mode 0).
- ss is active-high (asserted = 1), matching the slave.

Parameters:
- CLK_DIV, 5, sclk half-period in sys_clk cycles; legal range >= 1.
- SETUP_CYC, 2, sys_clk cycles from ss rise to the start of the first sclk low half-period count.
- GAP_CYC, 10, minimum idle sys_clk cycles after ss falls before the next byte is accepted.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to send; sampled only at handshake.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; handshake = tx_valid & tx_ready.
- rx_data  out  8  byte captured from miso in the last frame.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high in every state except IDLE.
- ss  out  1  slave select, active-high.
- sclk  out  1  serial clock, idle 0.
- mosi  out  1  serial data to the slave.
- miso  in  1  serial data from the slave.

Behaviour:
- Reset (rst_n = 0, asynchronous, effective immediately, including mid-frame):
  - ss = 0, sclk = 0, mosi = 0, rx_data = 0x00, rx_valid = 0, busy = 0.
  - State goes to IDLE, so tx_ready = 1. Shift registers and counters clear.
  - A frame interrupted by reset produces no rx_valid.
- State machine: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - On handshake, latch tx_data into tx_shift. Next registered values: ss = 1, mosi = tx_data[7], busy = 1, state = SETUP.
  - tx_valid without handshake has no effect.
- SETUP:
  - Lasts SETUP_CYC cycles with sclk = 0, then enter SHIFT.
- SHIFT:
  - Half-period counter runs 0..CLK_DIV-1; sclk toggles at each wrap. 16 toggles total, i.e. 8 rising and 8 falling edges.
  - At the sys_clk edge that drives sclk 0 -> 1: sample miso and shift it into the rx_shift LSB. Bit order is MSB first.
  - At the sys_clk edge that drives sclk 1 -> 0 (toggles 2, 4, ..., 14): mosi takes the next tx bit (tx_data[6] down to tx_data[0]).
  - After toggle 16, sclk = 0 and mosi holds bit 0; enter HOLD.
- HOLD:
  - Lasts CLK_DIV cycles. On exit: ss = 0, mosi = 0, rx_data = rx_shift, rx_valid = 1 for exactly one cycle, state = GAP.
- GAP:
  - Lasts GAP_CYC cycles with ss = 0 and busy = 1, then IDLE.
- Timing:
  - ss high duration is exactly SETUP_CYC + 17*CLK_DIV cycles (87 with defaults).
  - rx_valid is asserted in the first cycle ss is low.
  - Minimum ss low time between back-to-back frames is GAP_CYC + 1 cycles.
- Boundary conditions:
  - tx_data/tx_valid changes while busy are ignored.
  - CLK_DIV = 1: sclk toggles every sys_clk cycle; the behaviour above still holds.
  - miso is not synchronised; the slave must be synchronous to sys_clk or pre-synchronised at the top level.
  - Command/data pairing is done by the caller, which issues two byte transfers.

Optional Feature:
- Macro SPI_RX_CAPTURE_EN.
- Defined: miso capture, rx_data and rx_valid behave as above.
- Undefined: the rx_shift register is not built; rx_data is tied to 0x00 and rx_valid to 0; miso is unused. Transmit timing is identical in both builds.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> ss = 0, sclk = 0, mosi = 0, rx_data = 0x00, rx_valid = 0, busy = 0, tx_ready = 1.
- Send 0x80, miso = 0, defaults -> mosi sampled at the 8 sclk rises is 1,0,0,0,0,0,0,0; ss high exactly 87 cycles; rx_data = 0x00 with a one-cycle rx_valid.
- Loopback miso = mosi, send 0xA5 -> rx_data = 0xA5, rx_valid is a single cycle coincident with the first ss-low cycle; tx_ready returns 10 cycles later.
- Back-to-back 0x9B then 0xAA with tx_valid held high -> two ss frames separated by exactly 11 low cycles; mosi bits 10011011 then 10101010.
- Assert rst_n low just after the 4th sclk rise while sending 0xFF -> ss, sclk and mosi go 0 immediately, with no rx_valid. A subsequent 0x3C transfer completes normally, and loopback gives rx_data = 0x3C.
- CLK_DIV = 1, SETUP_CYC = 0, loopback 0x5A -> rx_data = 0x5A, ss high 17 cycles. Build without SPI_RX_CAPTURE_EN -> rx_data stays 0x00 and rx_valid never asserts, with mosi/ss timing unchanged.

Source files
------------

// File: rtl/spi_byte_master.sv
// spi_byte_master: mode-0 SPI initiator, one MSB-first byte per active-high ss frame.
// Build option SPI_RX_CAPTURE_EN: when defined, miso is shifted in and published on
// rx_data/rx_valid; when undefined the receive path is absent and rx outputs are tied low.
module spi_byte_master #(
   parameter int CLK_DIV   = 5,
   parameter int SETUP_CYC = 2,
   parameter int GAP_CYC   = 10
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       ss,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso
);
   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
   localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
   localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
   localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);
   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  tog_q, tog_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        ss_q, ss_d, sclk_q, sclk_d, mosi_q, mosi_d;
   logic        sample_en, frame_done;
   // Frame sequencing: one shared counter times setup, sclk half-periods, hold and gap.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tog_d      = tog_q;
      tx_shift_d = tx_shift_q;
      ss_d       = ss_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      sample_en  = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE: if (tx_valid) begin
            tx_shift_d = tx_data;
            ss_d       = 1'b1;
            mosi_d     = tx_data[7];
            cnt_d      = 16'd0;
            tog_d      = 4'd0;
            state_d    = (SETUP_CYC == 0) ? SHIFT : SETUP;
         end
         SETUP: if (cnt_q == SETUP_LAST) begin
            cnt_d   = 16'd0;
            state_d = SHIFT;
         end else cnt_d = cnt_q + 16'd1;
         SHIFT: if (cnt_q == DIV_LAST) begin
            cnt_d  = 16'd0;
            sclk_d = ~sclk_q;
            tog_d  = tog_q + 4'd1;
            if (!sclk_q) sample_en = 1'b1;
            else if (tog_q == 4'd15) state_d = HOLD;
            else begin
               mosi_d     = tx_shift_q[6];
               tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
         end else cnt_d = cnt_q + 16'd1;
         HOLD: if (cnt_q == DIV_LAST) begin
            cnt_d      = 16'd0;
            ss_d       = 1'b0;
            mosi_d     = 1'b0;
            frame_done = 1'b1;
            state_d    = (GAP_CYC == 0) ? IDLE : GAP;
         end else cnt_d = cnt_q + 16'd1;
         GAP: if (cnt_q == GAP_LAST) begin
            cnt_d   = 16'd0;
            state_d = IDLE;
         end else cnt_d = cnt_q + 16'd1;
         default: state_d = IDLE;
      endcase
   end
   // Control and transmit registers; reset aborts any frame immediately.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 16'd0;
         tog_q      <= 4'd0;
         tx_shift_q <= 8'h00;
         ss_q       <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tog_q      <= tog_d;
         tx_shift_q <= tx_shift_d;
         ss_q       <= ss_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
      end
   end
   assign tx_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign ss       = ss_q;
   assign sclk     = sclk_q;
   assign mosi     = mosi_q;
`ifdef SPI_RX_CAPTURE_EN
   logic [7:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   // Shift miso in on each sclk rise; publish the byte as the frame closes.
   always_comb begin
      rx_shift_d = sample_en ? {rx_shift_q[6:0], miso} : rx_shift_q;
      rx_data_d  = frame_done ? rx_shift_q : rx_data_q;
      rx_valid_d = frame_done;
   end
   // Receive registers.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_shift_q <= 8'h00;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
      end else begin
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
`else
   logic unused_rx;
   assign unused_rx = miso ^ sample_en ^ frame_done;
   assign rx_data   = 8'h00;
   assign rx_valid  = 1'b0;
`endif
endmodule
